impact_sram_driver: RTL and testbench

IMPACT_SRAM_DRIVER -- requirements
Module: impact_sram_driver

---
 rtl/impact_sram_pkg.sv | 24 ++
 rtl/impact_sram_driver.sv | 134 +++++++++++++
 tb/tb_impact_sram_driver.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/impact_sram_pkg.sv
// Shared types and defaults for the IMPACT SRAM macro driver: FSM states,
// default phase lengths and the latched command record.
package impact_sram_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_PRECH  = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   localparam int PRE_CYC_DEF = 2;
   localparam int WL_CYC_DEF  = 2;

   typedef struct packed {
      logic       we;
      logic [1:0] byte_sel;
      logic [1:0] proj_sel;
      logic       byte_mode;
      logic       trunc;
      logic [7:0] wdata;
   } cmd_t;

endpackage

// File: rtl/impact_sram_driver.sv
// Single-command SRAM macro driver: precharge phase, word-line access phase,
// then a held response until consumed. All macro strobes are registered.
module impact_sram_driver
   import impact_sram_pkg::*;
#(
   parameter int PRE_CYC = PRE_CYC_DEF,
   parameter int WL_CYC  = WL_CYC_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_we,
   input  logic [1:0] cmd_byte_sel,
   input  logic [1:0] cmd_proj_sel,
   input  logic       cmd_byte_mode,
   input  logic       cmd_trunc,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_we,
   output logic [7:0] rsp_rdata,
   output logic       sram_precharge,
   output logic       sram_wl_enable,
   output logic       sram_data_in_enable,
   output logic       sram_write_enable,
   output logic       sram_read_enable,
   output logic       sram_byte_mode_enable,
   output logic       sram_trunc_enable,
   output logic [1:0] sram_byte_select,
   output logic [1:0] sram_proj_select,
   output logic [7:0] sram_data_in,
   input  logic [7:0] sram_data_out,
   output logic       busy
);

   localparam logic [3:0] PRE_LOAD = 4'(PRE_CYC - 1);
   localparam logic [3:0] WL_LOAD  = 4'(WL_CYC - 1);

   state_t     state_q, state_nxt;
   logic [3:0] cnt_q, cnt_nxt;
   cmd_t       cmd_q;
   logic       accept;
   logic       last_access;
   logic       pre_nxt, wl_nxt, wr_nxt, rd_nxt, rsp_valid_nxt;

   // cmd_ready is gated by rst_n so it is low while reset is held, yet the
   // very first edge after release can already accept a command.
   assign cmd_ready   = (state_q == S_IDLE) && rst_n;
   assign busy        = (state_q != S_IDLE);
   assign accept      = cmd_valid && cmd_ready;
   assign last_access = (state_q == S_ACCESS) && (cnt_q == 4'd0);

   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_nxt = S_PRECH;
               cnt_nxt   = PRE_LOAD;
            end
         end
         S_PRECH: begin
            if (cnt_q == 4'd0) begin
               state_nxt = S_ACCESS;
               cnt_nxt   = WL_LOAD;
            end else begin
               cnt_nxt = cnt_q - 4'd1;
            end
         end
         S_ACCESS: begin
            if (cnt_q == 4'd0) state_nxt = S_RESP;
            else               cnt_nxt   = cnt_q - 4'd1;
         end
         S_RESP: begin
            if (rsp_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase

      // Strobes are decoded from the next state so the registers line up
      // exactly with the phase the FSM is entering.
      pre_nxt       = (state_nxt == S_PRECH);
      wl_nxt        = (state_nxt == S_ACCESS);
      wr_nxt        = wl_nxt && cmd_q.we;
      rd_nxt        = wl_nxt && !cmd_q.we;
      rsp_valid_nxt = (state_nxt == S_RESP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sram_precharge      <= 1'b0;
         sram_wl_enable      <= 1'b0;
         sram_write_enable   <= 1'b0;
         sram_data_in_enable <= 1'b0;
         sram_read_enable    <= 1'b0;
         rsp_valid           <= 1'b0;
         rsp_we              <= 1'b0;
         rsp_rdata           <= 8'h00;
         cmd_q               <= '0;
      end else begin
         sram_precharge      <= pre_nxt;
         sram_wl_enable      <= wl_nxt;
         sram_write_enable   <= wr_nxt;
         sram_data_in_enable <= wr_nxt;
         sram_read_enable    <= rd_nxt;
         rsp_valid           <= rsp_valid_nxt;
         if (accept) cmd_q <= '{cmd_we, cmd_byte_sel, cmd_proj_sel,
                                cmd_byte_mode, cmd_trunc, cmd_wdata};
         if (last_access) begin
            rsp_we    <= cmd_q.we;
            rsp_rdata <= cmd_q.we ? 8'h00 : sram_data_out;
         end
      end
   end

   assign sram_byte_select      = cmd_q.byte_sel;
   assign sram_proj_select      = cmd_q.proj_sel;
   assign sram_byte_mode_enable = cmd_q.byte_mode;
   assign sram_trunc_enable     = cmd_q.trunc;
   assign sram_data_in          = cmd_q.wdata;

endmodule

// File: tb/tb_impact_sram_driver.sv
// Directed bench for impact_sram_driver: default, short-precharge/long-access
// and long-precharge/short-access instances, cycle-exact strobe expectations.
module tb_impact_sram_driver;

   logic       clk;
   logic       rst_n;
   logic [2:0] cmd_valid_a;
   logic [2:0] rsp_ready_a;
   logic       cmd_we;
   logic [1:0] cmd_byte_sel;
   logic [1:0] cmd_proj_sel;
   logic       cmd_byte_mode;
   logic       cmd_trunc;
   logic [7:0] cmd_wdata;
   logic [7:0] sram_data_out;

   logic [2:0] cmd_ready_v, rsp_valid_v, rsp_we_v, pre_v, wl_v, din_en_v;
   logic [2:0] wen_v, ren_v, bm_v, tr_v, busy_v;
   logic [7:0] rdata_a [3];
   logic [7:0] din_a   [3];
   logic [1:0] bsel_a  [3];
   logic [1:0] psel_a  [3];

   int n_total = 0;
   int n_bad   = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      impact_sram_driver #(
         .PRE_CYC(g == 0 ? 2 : (g == 1 ? 1 : 15)),
         .WL_CYC (g == 0 ? 2 : (g == 1 ? 15 : 1))
      ) u_dut (
         .clk                  (clk),
         .rst_n                (rst_n),
         .cmd_valid            (cmd_valid_a[g]),
         .cmd_ready            (cmd_ready_v[g]),
         .cmd_we               (cmd_we),
         .cmd_byte_sel         (cmd_byte_sel),
         .cmd_proj_sel         (cmd_proj_sel),
         .cmd_byte_mode        (cmd_byte_mode),
         .cmd_trunc            (cmd_trunc),
         .cmd_wdata            (cmd_wdata),
         .rsp_valid            (rsp_valid_v[g]),
         .rsp_ready            (rsp_ready_a[g]),
         .rsp_we               (rsp_we_v[g]),
         .rsp_rdata            (rdata_a[g]),
         .sram_precharge       (pre_v[g]),
         .sram_wl_enable       (wl_v[g]),
         .sram_data_in_enable  (din_en_v[g]),
         .sram_write_enable    (wen_v[g]),
         .sram_read_enable     (ren_v[g]),
         .sram_byte_mode_enable(bm_v[g]),
         .sram_trunc_enable    (tr_v[g]),
         .sram_byte_select     (bsel_a[g]),
         .sram_proj_select     (psel_a[g]),
         .sram_data_in         (din_a[g]),
         .sram_data_out        (sram_data_out),
         .busy                 (busy_v[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pre_of(input int g);
      return (g == 0) ? 2 : ((g == 1) ? 1 : 15);
   endfunction

   function automatic int wl_of(input int g);
      return (g == 0) ? 2 : ((g == 1) ? 15 : 1);
   endfunction

   // {precharge, wl, data_in_en, write_en, read_en, rsp_valid, busy, cmd_ready}
   function automatic logic [7:0] obs_vec(input int g);
      return {pre_v[g], wl_v[g], din_en_v[g], wen_v[g], ren_v[g],
              rsp_valid_v[g], busy_v[g], cmd_ready_v[g]};
   endfunction

   function automatic logic [23:0] obs_pins(input int g);
      return {bsel_a[g], psel_a[g], bm_v[g], tr_v[g], din_a[g], rdata_a[g], rsp_we_v[g], 1'b0};
   endfunction

   // Exclusivity of precharge/word-line and write/read on every cycle.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         for (int g = 0; g < 3; g++) begin
            chk("mutex_pre_wl", {31'd0, pre_v[g] & wl_v[g]}, 32'd0);
            chk("mutex_we_re",  {31'd0, wen_v[g] & ren_v[g]}, 32'd0);
         end
      end
   end

   // Called at a negedge with the instance idle; leaves at the negedge after
   // the response handshake so another call can accept on the very next edge.
   task automatic do_txn(input int g, input logic we, input logic [7:0] wd,
                         input logic [1:0] bs, input logic [1:0] ps,
                         input logic bm, input logic tr,
                         input logic [7:0] rd, input int hold);
      int         pre_n, wl_n, last;
      logic       in_pre, in_acc, in_rsp;
      logic [7:0] exp_v, exp_rd;
      pre_n  = pre_of(g);
      wl_n   = wl_of(g);
      last   = pre_n + wl_n + 1 + hold;
      exp_rd = we ? 8'h00 : rd;
      chk("ready_before_accept", {31'd0, cmd_ready_v[g]}, 32'd1);
      cmd_we        = we;
      cmd_wdata     = wd;
      cmd_byte_sel  = bs;
      cmd_proj_sel  = ps;
      cmd_byte_mode = bm;
      cmd_trunc     = tr;
      cmd_valid_a[g] = 1'b1;
      sram_data_out  = 8'hFF;
      for (int c = 1; c <= last + 1; c++) begin
         @(negedge clk);
         if (c == last + 1) begin
            chk("idle_after_rsp", {24'd0, obs_vec(g)}, 32'h01);
            rsp_ready_a[g] = 1'b0;
         end else begin
            in_pre = (c <= pre_n);
            in_acc = (c > pre_n) && (c <= pre_n + wl_n);
            in_rsp = (c > pre_n + wl_n);
            exp_v  = {in_pre, in_acc, in_acc & we, in_acc & we, in_acc & ~we,
                      in_rsp, 1'b1, 1'b0};
            chk("strobes", {24'd0, obs_vec(g)}, {24'd0, exp_v});
            chk("held_pins", {18'd0, bsel_a[g], psel_a[g], bm_v[g], tr_v[g], din_a[g]},
                {18'd0, bs, ps, bm, tr, wd});
            if (in_rsp) chk("rsp_data", {23'd0, rsp_we_v[g], rdata_a[g]}, {23'd0, we, exp_rd});
            // Offer a conflicting command while busy; it must be ignored.
            cmd_valid_a[g] = !in_rsp;
            cmd_we        = ~we;
            cmd_wdata     = ~wd;
            cmd_byte_sel  = ~bs;
            cmd_proj_sel  = ~ps;
            cmd_byte_mode = ~bm;
            cmd_trunc     = ~tr;
            sram_data_out = (c == pre_n + wl_n) ? rd : 8'hFF;
            if (c == last) rsp_ready_a[g] = 1'b1;
         end
      end
   endtask

   task automatic do_mid_reset();
      cmd_we        = 1'b1;
      cmd_wdata     = 8'hE7;
      cmd_byte_sel  = 2'd3;
      cmd_proj_sel  = 2'd2;
      cmd_byte_mode = 1'b1;
      cmd_trunc     = 1'b1;
      cmd_valid_a[0] = 1'b1;
      @(negedge clk);
      cmd_valid_a[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("in_access_before_rst", {24'd0, obs_vec(0)}, 32'b0111_0010);
      rst_n = 1'b0;
      #1;
      chk("rst_strobes_drop", {24'd0, obs_vec(0)}, 32'd0);
      chk("rst_pins_clear", {8'd0, obs_pins(0)}, 32'd0);
      #2;
      rst_n = 1'b1;
      #1;
      chk("ready_after_rst", {24'd0, obs_vec(0)}, 32'h01);
   endtask

   initial begin
      rst_n         = 1'b0;
      cmd_valid_a   = 3'b000;
      rsp_ready_a   = 3'b000;
      cmd_we        = 1'b0;
      cmd_byte_sel  = 2'd0;
      cmd_proj_sel  = 2'd0;
      cmd_byte_mode = 1'b0;
      cmd_trunc     = 1'b0;
      cmd_wdata     = 8'h00;
      sram_data_out = 8'hFF;
      repeat (2) @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         chk("reset_strobes", {24'd0, obs_vec(g)}, 32'd0);
         chk("reset_pins", {8'd0, obs_pins(g)}, 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      for (int g = 0; g < 3; g++) chk("idle_after_reset", {24'd0, obs_vec(g)}, 32'h01);

      do_txn(0, 1'b1, 8'hA5, 2'd2, 2'd1, 1'b1, 1'b0, 8'h77, 0);
      do_txn(0, 1'b0, 8'h5C, 2'd1, 2'd3, 1'b0, 1'b1, 8'h3C, 10);
      do_mid_reset();
      do_txn(0, 1'b1, 8'h5A, 2'd0, 2'd2, 1'b0, 1'b1, 8'h11, 1);
      do_txn(1, 1'b0, 8'h00, 2'd3, 2'd0, 1'b1, 1'b1, 8'h81, 2);
      do_txn(1, 1'b1, 8'h96, 2'd1, 2'd1, 1'b0, 1'b0, 8'h42, 0);
      do_txn(2, 1'b1, 8'h0F, 2'd2, 2'd3, 1'b1, 1'b0, 8'h24, 0);
      do_txn(2, 1'b0, 8'hF0, 2'd0, 2'd1, 1'b0, 1'b1, 8'hC3, 3);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
